nes_pad_responder: RTL

//  Controller-side end of the NES serial gamepad link: emulates the pad's 4021 shift register.

---
 rtl/nes_pad_if.sv | 27 ++
 rtl/nes_pad_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_if.sv
// Serial gamepad link between a console (master) and the emulated pad (slave).
// With NES_PAD_TURBO_EN defined, the turbo_a/turbo_b auto-fire enables are added.
interface nes_pad_if #(
    parameter int NUM_BITS = 8
);
    logic                latch;
    logic                pulse;
    logic [NUM_BITS-1:0] buttons;
    logic                data;
    logic                busy;
`ifdef NES_PAD_TURBO_EN
    logic                turbo_a;
    logic                turbo_b;

    modport master (output latch, output pulse, output buttons,
                    output turbo_a, output turbo_b,
                    input  data,  input  busy);
    modport slave  (input  latch, input  pulse, input  buttons,
                    input  turbo_a, input  turbo_b,
                    output data,  output busy);
`else
    modport master (output latch, output pulse, output buttons,
                    input  data,  input  busy);
    modport slave  (input  latch, input  pulse, input  buttons,
                    output data,  output busy);
`endif
endinterface

// File: rtl/nes_pad_responder.sv
// Emulated NES pad shift register: latches button levels and serialises them, one per pulse.
// Optional auto-fire on A/B is compiled in with NES_PAD_TURBO_EN.
module nes_pad_responder #(
    parameter int NUM_BITS     = 8,
    parameter bit FILL_BIT     = 1'b1,
    parameter int TURBO_FRAMES = 4
) (
    input  logic      clk,
    input  logic      reset,
    nes_pad_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BIT_CNT_MAX = 4'(NUM_BITS);

    state_t              state_r;
    state_t              state_next_s;
    logic [1:0]          latch_sync_r;
    logic                latch_hist_r;
    logic [1:0]          pulse_sync_r;
    logic                pulse_hist_r;
    logic                latch_high_s;
    logic                latch_rise_s;
    logic                latch_fall_s;
    logic                pulse_rise_s;
    logic [NUM_BITS-1:0] buttons_eff_s;
    logic [NUM_BITS-1:0] shift_r;
    logic [NUM_BITS-1:0] shift_next_s;
    logic [3:0]          bit_cnt_r;
    logic [3:0]          bit_cnt_next_s;
    logic                data_r;
    logic                data_next_s;
    logic                busy_r;
    logic                busy_next_s;

    // Two-flop synchronisers plus one history flop for the console strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_sync_r <= 2'b00;
            latch_hist_r <= 1'b0;
            pulse_sync_r <= 2'b00;
            pulse_hist_r <= 1'b0;
        end else begin
            latch_sync_r <= {latch_sync_r[0], bus.latch};
            latch_hist_r <= latch_sync_r[1];
            pulse_sync_r <= {pulse_sync_r[0], bus.pulse};
            pulse_hist_r <= pulse_sync_r[1];
        end
    end

    assign latch_high_s = latch_sync_r[1];
    assign latch_rise_s = latch_sync_r[1] & ~latch_hist_r;
    assign latch_fall_s = ~latch_sync_r[1] & latch_hist_r;
    assign pulse_rise_s = pulse_sync_r[1] & ~pulse_hist_r;

`ifdef NES_PAD_TURBO_EN
    localparam logic [7:0] FRAME_WRAP = 8'(2 * TURBO_FRAMES - 1);
    localparam logic [7:0] FRAME_HALF = 8'(TURBO_FRAMES);

    logic [7:0] frame_cnt_r;
    logic       phase_s;

    // Console frame counter, one step per latch fall, driving the auto-fire phase
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= 8'd0;
        end else if (latch_fall_s) begin
            frame_cnt_r <= (frame_cnt_r == FRAME_WRAP) ? 8'd0 : frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Auto-fire masks A/B as released during the second half of each turbo period
    always_comb begin
        phase_s          = (frame_cnt_r >= FRAME_HALF);
        buttons_eff_s    = bus.buttons;
        buttons_eff_s[0] = bus.buttons[0] & ~(bus.turbo_a & phase_s);
        buttons_eff_s[1] = bus.buttons[1] & ~(bus.turbo_b & phase_s);
    end
`else
    assign buttons_eff_s = bus.buttons;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a latch rise always restarts the frame
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (latch_rise_s) state_next_s = ST_LOAD;
                else              state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (latch_fall_s) state_next_s = ST_SHIFT;
                else              state_next_s = ST_LOAD;
            end
            ST_SHIFT: begin
                if (latch_rise_s)                                    state_next_s = ST_LOAD;
                else if (pulse_rise_s && (bit_cnt_r == BIT_CNT_MAX)) state_next_s = ST_DONE;
                else                                                 state_next_s = ST_SHIFT;
            end
            ST_DONE: begin
                if (latch_rise_s) state_next_s = ST_LOAD;
                else              state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output/datapath logic: data always mirrors the next shift_reg LSB except once the frame is exhausted
    always_comb begin
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
        if (latch_rise_s) begin
            shift_next_s   = ~buttons_eff_s;
            bit_cnt_next_s = 4'd0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    // The fall cycle itself must not reload, so the snapshot stays that of the last high cycle
                    if (latch_high_s) begin
                        shift_next_s = ~buttons_eff_s;
                    end else if (latch_fall_s) begin
                        bit_cnt_next_s = 4'd1;
                    end else begin
                        shift_next_s = shift_r;
                    end
                end
                ST_SHIFT: begin
                    if (pulse_rise_s) begin
                        shift_next_s = {FILL_BIT, shift_r[NUM_BITS-1:1]};
                        if (bit_cnt_r < BIT_CNT_MAX) bit_cnt_next_s = bit_cnt_r + 4'd1;
                        else                         bit_cnt_next_s = bit_cnt_r;
                    end else begin
                        shift_next_s = shift_r;
                    end
                end
                default: begin
                    shift_next_s   = shift_r;
                    bit_cnt_next_s = bit_cnt_r;
                end
            endcase
        end
        data_next_s = (state_next_s == ST_DONE) ? FILL_BIT : shift_next_s[0];
        busy_next_s = (state_next_s == ST_SHIFT);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r   <= {NUM_BITS{1'b1}};
            bit_cnt_r <= 4'd0;
            data_r    <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            data_r    <= data_next_s;
            busy_r    <= busy_next_s;
        end
    end

    assign bus.data = data_r;
    assign bus.busy = busy_r;

endmodule
